// File: rtl/spr_file.sv
// Special-purpose register file holding the architectural interrupt state.
// Commits interrupt state on jisr, restores on eret, and serves SPR moves.
module spr_file #(
  parameter int W  = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ue,
  input  logic          jisr,
  input  logic          eret,
  input  logic [W-1:0]  sr_in,
  input  logic [W-1:0]  esr_in,
  input  logic [W-1:0]  eca_in,
  input  logic [W-1:0]  epc_in,
  input  logic [W-1:0]  edata_in,
  input  logic          mode_in,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic [W-1:0]  sr,
  output logic [W-1:0]  esr,
  output logic [W-1:0]  eca,
  output logic [W-1:0]  epc,
  output logic [W-1:0]  edata,
  output logic [W-1:0]  pto,
  output logic [W-1:0]  ptl,
  output logic          mode,
  output logic          emode,
  output logic          ill_wr
);

  localparam logic [AW-1:0] A_SR    = AW'(0);
  localparam logic [AW-1:0] A_ESR   = AW'(1);
  localparam logic [AW-1:0] A_ECA   = AW'(2);
  localparam logic [AW-1:0] A_EPC   = AW'(3);
  localparam logic [AW-1:0] A_EDATA = AW'(4);
  localparam logic [AW-1:0] A_PTO   = AW'(5);
  localparam logic [AW-1:0] A_PTL   = AW'(6);
  localparam logic [AW-1:0] A_EMODE = AW'(7);

  logic [W-1:0] sr_q, sr_d, esr_q, esr_d, eca_q, eca_d, epc_q, epc_d;
  logic [W-1:0] edata_q, edata_d, pto_q, pto_d, ptl_q, ptl_d;
  logic         mode_q, mode_d, emode_q, emode_d;

  // Priority jisr > eret > wr_en; user-mode writes are dropped.
  always_comb begin
    sr_d    = sr_q;
    esr_d   = esr_q;
    eca_d   = eca_q;
    epc_d   = epc_q;
    edata_d = edata_q;
    pto_d   = pto_q;
    ptl_d   = ptl_q;
    mode_d  = mode_q;
    emode_d = emode_q;
    if (ue) begin
      if (jisr) begin
        sr_d    = sr_in;
        esr_d   = esr_in;
        eca_d   = eca_in;
        epc_d   = epc_in;
        edata_d = edata_in;
        emode_d = mode_q;
        mode_d  = mode_in;
      end else if (eret) begin
        sr_d   = esr_q;
        mode_d = emode_q;
      end else if (wr_en && !mode_q) begin
        case (wr_addr)
          A_SR:    sr_d    = wr_data;
          A_ESR:   esr_d   = wr_data;
          A_ECA:   eca_d   = wr_data;
          A_EPC:   epc_d   = wr_data;
          A_EDATA: edata_d = wr_data;
          A_PTO:   pto_d   = wr_data;
          A_PTL:   ptl_d   = wr_data;
          A_EMODE: emode_d = wr_data[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      esr_q   <= '0;
      eca_q   <= '0;
      epc_q   <= '0;
      edata_q <= '0;
      pto_q   <= '0;
      ptl_q   <= '0;
      mode_q  <= 1'b0;
      emode_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      esr_q   <= esr_d;
      eca_q   <= eca_d;
      epc_q   <= epc_d;
      edata_q <= edata_d;
      pto_q   <= pto_d;
      ptl_q   <= ptl_d;
      mode_q  <= mode_d;
      emode_q <= emode_d;
    end
  end

  // Read path reflects current state only; a same-cycle write shows next cycle.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      A_SR:    rd_data = sr_q;
      A_ESR:   rd_data = esr_q;
      A_ECA:   rd_data = eca_q;
      A_EPC:   rd_data = epc_q;
      A_EDATA: rd_data = edata_q;
      A_PTO:   rd_data = pto_q;
      A_PTL:   rd_data = ptl_q;
      A_EMODE: rd_data = {{(W-1){1'b0}}, emode_q};
      default: rd_data = '0;
    endcase
  end

  assign ill_wr = wr_en & mode_q & ~jisr & ~eret & ue;

  assign sr    = sr_q;
  assign esr   = esr_q;
  assign eca   = eca_q;
  assign epc   = epc_q;
  assign edata = edata_q;
  assign pto   = pto_q;
  assign ptl   = ptl_q;
  assign mode  = mode_q;
  assign emode = emode_q;

endmodule

// File: tb/tb_spr_file.sv
// Directed bench for spr_file: reset, jisr/eret commit and restore,
// mode-gated writes, event priority, stall and read timing.
module tb_spr_file;

  localparam int W  = 32;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          ue, jisr, eret, mode_in, wr_en;
  logic [W-1:0]  sr_in, esr_in, eca_in, epc_in, edata_in, wr_data;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [W-1:0]  rd_data, sr, esr, eca, epc, edata, pto, ptl;
  logic          mode, emode, ill_wr;

  int n_vec;
  int n_err;
  logic [W-1:0] exp_q[$];

  spr_file #(.W(W), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ue(ue), .jisr(jisr), .eret(eret),
    .sr_in(sr_in), .esr_in(esr_in), .eca_in(eca_in), .epc_in(epc_in),
    .edata_in(edata_in), .mode_in(mode_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .sr(sr), .esr(esr), .eca(eca), .epc(epc), .edata(edata),
    .pto(pto), .ptl(ptl), .mode(mode), .emode(emode), .ill_wr(ill_wr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ue = 1'b1; jisr = 1'b0; eret = 1'b0; wr_en = 1'b0; mode_in = 1'b0;
    sr_in = '0; esr_in = '0; eca_in = '0; epc_in = '0; edata_in = '0;
    wr_addr = '0; wr_data = '0;
  endtask

  task automatic spr_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_jisr(input logic [W-1:0] s, input logic [W-1:0] es, input logic [W-1:0] ec,
                         input logic [W-1:0] ep, input logic [W-1:0] ed, input logic m);
    jisr = 1'b1; sr_in = s; esr_in = es; eca_in = ec; epc_in = ep; edata_in = ed; mode_in = m;
    step();
    jisr = 1'b0;
  endtask

  // pops exp_q against rd_data for addresses 0..7
  task automatic read_sweep(input string tag);
    logic [W-1:0] e;
    for (int a = 0; a < 8; a++) begin
      rd_addr = AW'(a);
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s_rd%0d", tag, a), rd_data, e);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    rd_addr = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check("rst_sr", sr, 0);
    check("rst_mode", mode, 0);
    check("rst_emode", emode, 0);
    check("rst_ill", ill_wr, 0);

    // load every SPR with a non-zero value from system mode
    for (int k = 0; k < 7; k++) spr_write(AW'(k), 32'h100 + k);
    spr_write(3'd7, 32'hFFFF_FFF1);
    for (int k = 0; k < 7; k++) exp_q.push_back(32'h100 + k);
    exp_q.push_back(32'h1);
    read_sweep("load");
    check("load_pto", pto, 32'h105);
    check("load_emode", emode, 1);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_sr", sr, 0);
    check("arst_esr", esr, 0);
    check("arst_pto", pto, 0);
    check("arst_ptl", ptl, 0);
    check("arst_emode", emode, 0);
    for (int k = 0; k < 8; k++) exp_q.push_back('0);
    read_sweep("arst");
    rst_n = 1'b1;
    step();

    // enter user mode, then take the reference interrupt from user mode
    spr_write(3'd5, 32'h55);
    do_jisr(32'h11, 32'h22, 32'h33, 32'h44, 32'h66, 1'b1);
    check("j1_mode", mode, 1);
    check("j1_emode", emode, 0);
    do_jisr(32'h0, 32'hFF, 32'h2, 32'h4, 32'h77, 1'b0);
    check("j2_eca", eca, 32'h2);
    check("j2_epc", epc, 32'h4);
    check("j2_esr", esr, 32'hFF);
    check("j2_sr", sr, 32'h0);
    check("j2_mode", mode, 0);
    check("j2_emode", emode, 1);
    check("j2_pto", pto, 32'h55);
    check("j2_ptl", ptl, 32'h0);

    // return from exception
    eret = 1'b1;
    step();
    eret = 1'b0;
    check("eret_sr", sr, 32'hFF);
    check("eret_mode", mode, 1);
    check("eret_eca", eca, 32'h2);
    check("eret_epc", epc, 32'h4);
    check("eret_esr", esr, 32'hFF);

    // user-mode write is dropped and flagged
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h1000;
    #1 check("uwr_ill", ill_wr, 1);
    step();
    check("uwr_pto", pto, 32'h55);
    // same write stalled: no flag
    ue = 1'b0;
    #1 check("uwr_stall_ill", ill_wr, 0);
    step();
    wr_en = 1'b0; ue = 1'b1;

    // all three events while stalled: nothing changes
    ue = 1'b0; jisr = 1'b1; eret = 1'b1; wr_en = 1'b1;
    sr_in = 32'hA1; esr_in = 32'hA2; eca_in = 32'hA3; epc_in = 32'hA4; edata_in = 32'hA5;
    mode_in = 1'b0; wr_addr = 3'd6; wr_data = 32'hBEEF;
    #1 check("col_stall_ill", ill_wr, 0);
    step();
    check("col_stall_sr", sr, 32'hFF);
    check("col_stall_eca", eca, 32'h2);
    check("col_stall_mode", mode, 1);
    check("col_stall_ptl", ptl, 32'h0);
    // same events with ue: only jisr applies
    ue = 1'b1;
    #1 check("col_ill", ill_wr, 0);
    step();
    jisr = 1'b0;
    check("col_sr", sr, 32'hA1);
    check("col_esr", esr, 32'hA2);
    check("col_eca", eca, 32'hA3);
    check("col_epc", epc, 32'hA4);
    check("col_edata", edata, 32'hA5);
    check("col_mode", mode, 0);
    check("col_emode", emode, 1);
    check("col_ptl", ptl, 32'h0);
    // eret beats a system-mode write
    step();
    eret = 1'b0; wr_en = 1'b0;
    check("ew_sr", sr, 32'hA2);
    check("ew_mode", mode, 1);
    check("ew_ptl", ptl, 32'h0);

    // back to system mode, then a legal write
    do_jisr(32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 1'b0);
    check("sys_mode", mode, 0);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h1000; rd_addr = 3'd5;
    #1 check("swr_ill", ill_wr, 0);
    step();
    wr_en = 1'b0;
    check("swr_pto", pto, 32'h1000);
    check("swr_rd", rd_data, 32'h1000);

    // no write-to-read bypass
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hABCD; rd_addr = 3'd2;
    #1 check("byp_old", rd_data, 32'hA3);
    step();
    wr_en = 1'b0;
    check("byp_new", rd_data, 32'hABCD);

    // reset asserted during a jisr cycle wins
    jisr = 1'b1; sr_in = 32'h99; mode_in = 1'b1;
    #2 rst_n = 1'b0;
    step();
    jisr = 1'b0;
    check("rj_sr", sr, 0);
    check("rj_mode", mode, 0);
    rst_n = 1'b1;
    step();
    check("rj_eca", eca, 0);
    check("rj_emode", emode, 0);
    check("rj_pto", pto, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spr_file.md
Name: spr_file

Overview:
- Special-purpose register file sitting directly downstream of main_interrupt.
- Holds the architectural interrupt state: sr, esr, eca, epc, edata, pto, ptl, mode, emode.
- Commits main_interrupt's *_out values on jisr, restores state on eret, and serves movg2s/movs2g-style reads and writes from the datapath.
- Its register outputs feed back into main_interrupt's sr, esr and mode inputs, and feed the MMU (pto, ptl).

Parameters:
- W, 32, data width of every SPR.
- AW, 3, SPR address width (8 SPRs).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ue  in  1  update enable; 0 = pipeline stall, no state change
- jisr  in  1  interrupt taken, from main_interrupt
- eret  in  1  return-from-exception instruction in execute
- sr_in  in  W  main_interrupt sr_out
- esr_in  in  W  main_interrupt esr_out
- eca_in  in  W  main_interrupt eca_out
- epc_in  in  W  main_interrupt epc_out
- edata_in  in  W  main_interrupt edata_out
- mode_in  in  1  main_interrupt mode_out (mode after jisr)
- wr_en  in  1  SPR write request (movg2s)
- wr_addr  in  AW  SPR write address
- wr_data  in  W  SPR write data
- rd_addr  in  AW  SPR read address (movs2g)
- rd_data  out  W  SPR read data
- sr, esr, eca, epc, edata, pto, ptl  out  W  architectural SPR values
- mode  out  1  current mode: 0 = system, 1 = user
- emode  out  1  saved mode
- ill_wr  out  1  write attempted in user mode (dropped)

Behaviour:
- Address map:
  - 0 sr
  - 1 esr
  - 2 eca
  - 3 epc
  - 4 edata
  - 5 pto
  - 6 ptl
  - 7 emode (bit 0 only; reads return {31'b0, emode}).
- Reset (rst_n = 0, asynchronous, effective immediately, including mid-operation): all SPRs = 0, mode = 0, emode = 0. ill_wr is combinational and therefore 0 while wr_en = 0.
- All state updates occur on rising clk edges only, and only when ue = 1. When ue = 0, every register holds its value regardless of jisr, eret or wr_en.
- Event priority within one cycle: jisr > eret > wr_en. Lower-priority events in the same cycle are discarded entirely.
- jisr = 1 (one cycle later):
  - sr ← sr_in, esr ← esr_in, eca ← eca_in, epc ← epc_in, edata ← edata_in
  - emode ← mode (pre-update value), mode ← mode_in
  - pto and ptl unchanged.
- eret = 1 and jisr = 0 (one cycle later): sr ← esr, mode ← emode. All other SPRs unchanged.
- wr_en = 1 with no jisr or eret:
  - mode = 0: SPR[wr_addr] ← wr_data; address 7 writes only wr_data[0] into emode.
  - mode = 1: write dropped; ill_wr = 1 combinationally in that cycle.
  - ill_wr = wr_en & mode & ~jisr & ~eret & ue.
- Read path: rd_data = SPR[rd_addr], purely combinational from current register state. No write-to-read bypass: a same-cycle write is visible from the next cycle.
- Latency: every update is visible on outputs exactly 1 clk after the qualifying edge.
- Full-width stores, no truncation. No wrap-around arithmetic is involved.
- Reset asserted during a jisr cycle: reset wins; all values are 0 after release.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle with all SPRs non-zero → all outputs 0 immediately, mode = 0, rd_data = 0 for addresses 0–7.
- Interrupt commit: mode = 1, jisr = 1, ue = 1, eca_in = 32'h0000_0002, epc_in = 32'h0000_0004, esr_in = 32'hFF, sr_in = 0, mode_in = 0 → next cycle eca = 2, epc = 4, esr = 32'hFF, sr = 0, mode = 0, emode = 1.
- Return from exception: eret = 1 following the previous case → next cycle sr = 32'hFF, mode = 1; eca, epc and esr unchanged.
- Writes by mode:
  - mode = 0, wr_en = 1, wr_addr = 5, wr_data = 32'h1000 → pto = 32'h1000 and rd_addr = 5 reads 32'h1000 next cycle.
  - mode = 1, same write → pto unchanged, ill_wr = 1 in that cycle.
- Collisions and stall:
  - jisr = 1, eret = 1, wr_en = 1 in the same cycle → only the jisr update is applied.
  - Same stimulus with ue = 0 → no register changes and ill_wr = 0.
- Read timing: wr_en = 1, wr_addr = 2, rd_addr = 2 in the same cycle → rd_data shows the old eca that cycle and the new value the next cycle.
